controlador_contador16: RTL and testbench

- Sequencer for the 16-bit up/down/load counter, which has ports CLK, ENB, MODO[1:0], entrada[15:0], RCO and salida[15:0].
- Accepts one command: start value, count mode and number of count cycles. It then:
  - performs a parallel load (MODO=11);
  - runs the counter for exactly the commanded number of enabled cycles;
  - tallies RCO events;
  - returns the final counter value with a one-cycle DONE pulse.
- Sits between the test/control logic and the counter instance, and is the only driver of the counter's ENB/MODO/entrada.

---
 rtl/ctrl_contador_pkg.sv | 24 ++
 rtl/controlador_contador16_if.sv | 30 +++
 rtl/cont_restante.sv | 38 +++
 rtl/controlador_contador16.sv | 160 ++++++++++++++++
 tb/tb_controlador_contador16.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_contador_pkg.sv
// Shared types and constants for the 16-bit counter sequencer.
package ctrl_contador_pkg;

   localparam int ANCHO_DEF     = 16;
   localparam int ANCHO_RCO_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CARGA  = 2'd1,
      CUENTA = 2'd2,
      FIN    = 2'd3
   } estado_t;

   localparam logic [1:0] MODO_ARRIBA = 2'b00;
   localparam logic [1:0] MODO_ABAJO  = 2'b01;
   localparam logic [1:0] MODO_ABAJO3 = 2'b10;
   localparam logic [1:0] MODO_CARGA  = 2'b11;

   // Parallel load is reserved for the sequencer itself, never a count mode.
   function automatic logic modo_valido(input logic [1:0] modo);
      return modo != MODO_CARGA;
   endfunction

endpackage

// File: rtl/controlador_contador16_if.sv
// Command/status bus between the test/control logic and the sequencer.
interface controlador_contador16_if
   import ctrl_contador_pkg::*;
#(
   parameter int ANCHO     = ANCHO_DEF,
   parameter int ANCHO_RCO = ANCHO_RCO_DEF
) ();

   logic                 START;
   logic                 ABORT;
   logic [1:0]           MODO_REQ;
   logic [ANCHO-1:0]     VALOR_INI;
   logic [ANCHO-1:0]     N_CICLOS;
   logic                 BUSY;
   logic                 DONE;
   logic                 ERR;
   logic [ANCHO_RCO-1:0] N_RCO;
   logic [ANCHO-1:0]     RESULTADO;

   modport master (
      output START, ABORT, MODO_REQ, VALOR_INI, N_CICLOS,
      input  BUSY, DONE, ERR, N_RCO, RESULTADO
   );

   modport slave (
      input  START, ABORT, MODO_REQ, VALOR_INI, N_CICLOS,
      output BUSY, DONE, ERR, N_RCO, RESULTADO
   );

endinterface

// File: rtl/cont_restante.sv
// Remaining-cycles down-counter: loaded at command accept, decremented in CUENTA.
module cont_restante #(
   parameter int ANCHO = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             carga,
   input  logic [ANCHO-1:0] valor,
   input  logic             dec,
   output logic             ultimo,
   output logic             cero
);

   localparam logic [ANCHO-1:0] UNO = {{(ANCHO-1){1'b0}}, 1'b1};

   logic [ANCHO-1:0] cnt_q;
   logic [ANCHO-1:0] cnt_d;

   // Load has priority; decrement stops at zero so the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (carga) begin
         cnt_d = valor;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - UNO;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign ultimo = (cnt_q == UNO);
   assign cero   = (cnt_q == '0);

endmodule

// File: rtl/controlador_contador16.sv
// Sequencer for the 16-bit up/down/load counter: load, count N cycles,
// tally RCO, capture the final value.
//
//   state  | meaning
//   IDLE   | waiting for START, counter disabled
//   CARGA  | one-cycle parallel load of the start value
//   CUENTA | counting in the requested mode for N_CICLOS cycles
//   FIN    | counter frozen, DONE pulse, result captured on exit
module controlador_contador16
   import ctrl_contador_pkg::*;
#(
   parameter int ANCHO     = ANCHO_DEF,
   parameter int ANCHO_RCO = ANCHO_RCO_DEF
) (
   input  logic                       CLK,
   input  logic                       RESET,
   controlador_contador16_if.slave    bus,
   input  logic                       RCO,
   input  logic [ANCHO-1:0]           salida,
   output logic                       ENB,
   output logic [1:0]                 MODO,
   output logic [ANCHO-1:0]           entrada
);

   localparam logic [ANCHO_RCO-1:0] UNO_RCO = {{(ANCHO_RCO-1){1'b0}}, 1'b1};

   estado_t              state_q, state_d;
   logic [1:0]           modo_req_q, modo_req_d;
   logic                 enb_q, enb_d;
   logic [1:0]           modo_q, modo_d;
   logic [ANCHO-1:0]     entrada_q, entrada_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [ANCHO_RCO-1:0] n_rco_q, n_rco_d;
   logic [ANCHO-1:0]     resultado_q, resultado_d;

   logic rest_carga;
   logic rest_dec;
   logic rest_ultimo;
   logic rest_cero;

   // Remaining cycles are loaded straight from the command so CARGA can test for zero.
   cont_restante #(.ANCHO(ANCHO)) u_restante (
      .clk    (CLK),
      .rst    (RESET),
      .carga  (rest_carga),
      .valor  (bus.N_CICLOS),
      .dec    (rest_dec),
      .ultimo (rest_ultimo),
      .cero   (rest_cero)
   );

   // Next state and next value of every registered output.
   always_comb begin
      state_d     = state_q;
      modo_req_d  = modo_req_q;
      enb_d       = 1'b0;
      modo_d      = MODO_ARRIBA;
      entrada_d   = entrada_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      n_rco_d     = n_rco_q;
      resultado_d = resultado_q;
      rest_carga  = 1'b0;
      rest_dec    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.START) begin
               if (!modo_valido(bus.MODO_REQ)) begin
                  err_d = 1'b1;
               end else begin
                  state_d    = CARGA;
                  modo_req_d = bus.MODO_REQ;
                  entrada_d  = bus.VALOR_INI;
                  enb_d      = 1'b1;
                  modo_d     = MODO_CARGA;
                  busy_d     = 1'b1;
                  n_rco_d    = '0;
                  rest_carga = 1'b1;
               end
            end
         end
         CARGA: begin
            if (bus.ABORT) begin
               state_d = IDLE;
            end else if (rest_cero) begin
               state_d = FIN;
               done_d  = 1'b1;
            end else begin
               state_d = CUENTA;
               enb_d   = 1'b1;
               modo_d  = modo_req_q;
               busy_d  = 1'b1;
            end
         end
         CUENTA: begin
            rest_dec = 1'b1;
            // The counter advances on this edge even when aborting, so its RCO counts.
            if (RCO && (n_rco_q != '1)) begin
               n_rco_d = n_rco_q + UNO_RCO;
            end
            if (bus.ABORT) begin
               state_d = IDLE;
            end else if (rest_ultimo) begin
               state_d = FIN;
               done_d  = 1'b1;
            end else begin
               enb_d  = 1'b1;
               modo_d = modo_req_q;
               busy_d = 1'b1;
            end
         end
         FIN: begin
            state_d     = IDLE;
            resultado_d = salida;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         modo_req_q  <= MODO_ARRIBA;
         enb_q       <= 1'b0;
         modo_q      <= MODO_ARRIBA;
         entrada_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         n_rco_q     <= '0;
         resultado_q <= '0;
      end else begin
         state_q     <= state_d;
         modo_req_q  <= modo_req_d;
         enb_q       <= enb_d;
         modo_q      <= modo_d;
         entrada_q   <= entrada_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         n_rco_q     <= n_rco_d;
         resultado_q <= resultado_d;
      end
   end

   assign ENB           = enb_q;
   assign MODO          = modo_q;
   assign entrada       = entrada_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
   assign bus.ERR       = err_q;
   assign bus.N_RCO     = n_rco_q;
   assign bus.RESULTADO = resultado_q;

endmodule

// File: tb/tb_controlador_contador16.sv
// Bench for controlador_contador16 with a behavioural counter attached.
module tb_controlador_contador16;
   import ctrl_contador_pkg::*;

   localparam int ANCHO     = 16;
   localparam int ANCHO_RCO = 2;
   localparam int SAT       = (1 << ANCHO_RCO) - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rco;
   logic [15:0] salida;
   logic        enb;
   logic [1:0]  modo;
   logic [15:0] entrada;

   controlador_contador16_if #(.ANCHO(ANCHO), .ANCHO_RCO(ANCHO_RCO)) bus ();

   controlador_contador16 #(.ANCHO(ANCHO), .ANCHO_RCO(ANCHO_RCO)) dut (
      .CLK     (clk),
      .RESET   (rst),
      .bus     (bus),
      .RCO     (rco),
      .salida  (salida),
      .ENB     (enb),
      .MODO    (modo),
      .entrada (entrada)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // External counter: up, down, down-by-3, load; RCO flags a wrap on the coming edge.
   logic [15:0] cnt = 16'h0000;
   always @(posedge clk) begin
      if (enb) begin
         case (modo)
            2'b00:   cnt <= cnt + 16'd1;
            2'b01:   cnt <= cnt - 16'd1;
            2'b10:   cnt <= cnt - 16'd3;
            default: cnt <= entrada;
         endcase
      end
   end
   assign salida = cnt;
   assign rco = enb && (((modo == 2'b00) && (cnt == 16'hFFFF)) ||
                        ((modo == 2'b01) && (cnt == 16'h0000)) ||
                        ((modo == 2'b10) && (cnt < 16'd3)));

   typedef struct {
      bit          es_err;
      int          ciclo;
      logic [15:0] res;
      int          nrco;
   } esp_t;

   esp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [15:0] ult_res = 16'h0000;
   int          ult_nrco = 0;

   task automatic chk(input string nombre, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nombre, act, req, cyc);
      end
   endtask

   // Final value and wrap count from plain arithmetic on the command.
   function automatic void modelo(input int v, input int m, input int n,
                                  output logic [15:0] r, output int w);
      int d;
      int t;
      if (m == 0) begin
         t = v + n;
         w = t / 65536;
      end else begin
         d = (m == 1) ? n : 3 * n;
         t = v - d;
         w = (d > v) ? (d - v - 1) / 65536 + 1 : 0;
      end
      r = t[15:0];
   endfunction

   function automatic esp_t preparar(input int v, input int m, input int n);
      esp_t        e;
      logic [15:0] r;
      int          w;
      if (m == 3) begin
         e.es_err = 1'b1;
         e.ciclo  = cyc + 1;
         e.res    = ult_res;
         e.nrco   = ult_nrco;
      end else begin
         modelo(v, m, n, r, w);
         e.es_err = 1'b0;
         e.ciclo  = cyc + n + 2;
         e.res    = r;
         e.nrco   = (w > SAT) ? SAT : w;
         ult_res  = r;
         ult_nrco = e.nrco;
      end
      return e;
   endfunction

   task automatic enviar(input logic [15:0] v, input logic [1:0] m, input logic [15:0] n);
      @(negedge clk);
      bus.START     = 1'b1;
      bus.VALOR_INI = v;
      bus.MODO_REQ  = m;
      bus.N_CICLOS  = n;
      sb.push_back(preparar(int'(v), int'(m), int'(n)));
      @(negedge clk);
      bus.START = 1'b0;
      repeat ((m == 2'b11) ? 1 : int'(n) + 3) @(negedge clk);
   endtask

   // Monitor: every DONE or ERR pops one expectation.
   initial begin
      esp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (bus.DONE || bus.ERR)) begin
            if (sb.size() == 0) begin
               chk("unexpected_event", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("event_kind_err", int'(bus.ERR), int'(e.es_err));
               chk("event_cycle", cyc, e.ciclo);
               chk("n_rco", int'(bus.N_RCO), e.nrco);
               chk("busy_at_event", int'(bus.BUSY), 0);
               if (e.es_err) begin
                  chk("enb_on_err", int'(enb), 0);
                  chk("resultado_kept", int'(bus.RESULTADO), int'(e.res));
               end else begin
                  @(negedge clk);
                  chk("resultado", int'(bus.RESULTADO), int'(e.res));
               end
            end
         end
      end
   end

   initial begin
      logic [1:0]  m;
      logic [15:0] v;
      logic [15:0] n;

      bus.START     = 1'b0;
      bus.ABORT     = 1'b0;
      bus.MODO_REQ  = 2'b00;
      bus.VALOR_INI = 16'h0000;
      bus.N_CICLOS  = 16'h0000;

      repeat (2) @(negedge clk);
      chk("rst_enb", int'(enb), 0);
      chk("rst_modo", int'(modo), 0);
      chk("rst_entrada", int'(entrada), 0);
      chk("rst_busy", int'(bus.BUSY), 0);
      chk("rst_done", int'(bus.DONE), 0);
      chk("rst_err", int'(bus.ERR), 0);
      chk("rst_n_rco", int'(bus.N_RCO), 0);
      chk("rst_resultado", int'(bus.RESULTADO), 0);
      rst = 1'b0;

      // Up count across the wrap, with load and count phases observed.
      @(negedge clk);
      bus.START = 1'b1; bus.VALOR_INI = 16'hFFFD; bus.MODO_REQ = 2'b00; bus.N_CICLOS = 16'd5;
      sb.push_back(preparar(16'hFFFD, 0, 5));
      @(negedge clk);
      bus.START = 1'b0;
      chk("carga_enb", int'(enb), 1);
      chk("carga_modo", int'(modo), 3);
      chk("carga_entrada", int'(entrada), 16'hFFFD);
      @(negedge clk);
      chk("cuenta_enb", int'(enb), 1);
      chk("cuenta_modo", int'(modo), 0);
      chk("cuenta_busy", int'(bus.BUSY), 1);
      repeat (7) @(negedge clk);

      // Load only, then an illegal mode.
      enviar(16'h1234, 2'b00, 16'd0);
      enviar(16'h5555, 2'b11, 16'd5);

      // Busy-ignore and abort.
      @(negedge clk);
      bus.START = 1'b1; bus.VALOR_INI = 16'h0000; bus.MODO_REQ = 2'b00; bus.N_CICLOS = 16'd10;
      @(negedge clk);
      bus.START = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.START = 1'b1; bus.VALOR_INI = 16'h7777; bus.MODO_REQ = 2'b01;
      @(negedge clk);
      bus.START = 1'b0;
      @(negedge clk);
      bus.ABORT = 1'b1;
      @(negedge clk);
      bus.ABORT = 1'b0;
      chk("abort_enb", int'(enb), 0);
      chk("abort_busy", int'(bus.BUSY), 0);
      chk("abort_salida", int'(salida), 16'h0004);
      repeat (3) @(negedge clk);
      chk("abort_salida_frozen", int'(salida), 16'h0004);
      chk("abort_n_rco", int'(bus.N_RCO), 0);
      chk("abort_resultado", int'(bus.RESULTADO), int'(ult_res));
      ult_nrco = 0;

      // Asynchronous reset in the middle of CUENTA.
      @(negedge clk);
      bus.START = 1'b1; bus.VALOR_INI = 16'h0100; bus.MODO_REQ = 2'b01; bus.N_CICLOS = 16'd20;
      @(negedge clk);
      bus.START = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_enb", int'(enb), 0);
      chk("async_rst_busy", int'(bus.BUSY), 0);
      chk("async_rst_modo", int'(modo), 0);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      ult_res  = 16'h0000;
      ult_nrco = 0;
      enviar(16'h0010, 2'b01, 16'd20);

      // Randomized commands, biased toward the wrap points.
      for (int i = 0; i < 30; i++) begin
         m = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0:       v = 16'($urandom);
            1:       v = 16'hFFFF - 16'($urandom_range(0, 20));
            default: v = 16'($urandom_range(0, 20));
         endcase
         n = 16'($urandom_range(0, 40));
         enviar(v, m, n);
      end

      // Long down-by-3 run.
      enviar(16'h0002, 2'b10, 16'd60000);

      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      chk("queue_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
